// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and MEM-stage data access.
// One outstanding req/gnt/rvalid transaction; data has priority, bounded IF starvation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_if_valid,
    input  logic                  i_d_read,
    input  logic                  i_d_write,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_wstrb,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_d_valid,
    output logic                  o_stall_if,
    output logic                  o_stall_mem,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_wstrb,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_err_spur
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_d;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_if_valid;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_d_valid;
    logic                r_err_spur;
    logic [CNT_W-1:0]    r_starve;

    state_t              w_state_nx;
    logic                w_owner_d_nx;
    logic                w_mem_req_nx;
    logic                w_mem_we_nx;
    logic [ADDR_W-1:0]   w_mem_addr_nx;
    logic [DATA_W-1:0]   w_mem_wdata_nx;
    logic [STRB_W-1:0]   w_mem_wstrb_nx;
    logic [DATA_W-1:0]   w_if_rdata_nx;
    logic                w_if_valid_nx;
    logic [DATA_W-1:0]   w_d_rdata_nx;
    logic                w_d_valid_nx;
    logic                w_err_spur_nx;
    logic [CNT_W-1:0]    w_starve_nx;

    logic                w_d_want;
    logic                w_if_want;
    logic                w_starved;
    logic                w_grant_d;
    logic                w_grant_if;

    // Requests eligible for arbitration: a port completing this cycle sits out one cycle.
    assign w_d_want   = (i_d_read | i_d_write) & ~r_d_valid;
    assign w_if_want  = i_if_req & ~r_if_valid;
    assign w_starved  = w_if_want & (r_starve == CNT_W'(STARVE_MAX));
    assign w_grant_d  = w_d_want & ~w_starved;
    assign w_grant_if = w_if_want & ~w_grant_d;

    // Next-state and next-register logic for the transaction sequencer.
    always_comb begin
        w_state_nx     = r_state;
        w_owner_d_nx   = r_owner_d;
        w_mem_req_nx   = r_mem_req;
        w_mem_we_nx    = r_mem_we;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_mem_wstrb_nx = r_mem_wstrb;
        w_if_rdata_nx  = r_if_rdata;
        w_if_valid_nx  = 1'b0;
        w_d_rdata_nx   = r_d_rdata;
        w_d_valid_nx   = 1'b0;
        w_starve_nx    = r_starve;
        w_err_spur_nx  = r_err_spur | (i_mem_rvalid & (r_state != S_RESP));

        case (r_state)
            S_IDLE: begin
                if (!i_if_req) begin
                    w_starve_nx = '0;
                end
                if (w_grant_d) begin
                    w_state_nx     = S_REQ;
                    w_owner_d_nx   = 1'b1;
                    w_mem_req_nx   = 1'b1;
                    w_mem_we_nx    = i_d_write;
                    w_mem_addr_nx  = i_d_addr;
                    w_mem_wdata_nx = i_d_write ? i_d_wdata : '0;
                    w_mem_wstrb_nx = i_d_write ? i_d_wstrb : '0;
                    if (i_if_req && (r_starve != CNT_W'(STARVE_MAX))) begin
                        w_starve_nx = r_starve + CNT_W'(1);
                    end
                end else if (w_grant_if) begin
                    w_state_nx     = S_REQ;
                    w_owner_d_nx   = 1'b0;
                    w_mem_req_nx   = 1'b1;
                    w_mem_we_nx    = 1'b0;
                    w_mem_addr_nx  = i_if_addr;
                    w_mem_wdata_nx = '0;
                    w_mem_wstrb_nx = '0;
                    w_starve_nx    = '0;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    w_state_nx   = S_RESP;
                    w_mem_req_nx = 1'b0;
                end
            end
            S_RESP: begin
                if (i_mem_rvalid) begin
                    w_state_nx = S_IDLE;
                    if (r_owner_d) begin
                        w_d_valid_nx = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nx = i_mem_rdata;
                        end
                    end else begin
                        w_if_valid_nx = 1'b1;
                        w_if_rdata_nx = i_mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_mem_req_nx = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_valid   <= 1'b0;
            r_err_spur  <= 1'b0;
            r_starve    <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_owner_d   <= w_owner_d_nx;
            r_mem_req   <= w_mem_req_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_mem_wstrb <= w_mem_wstrb_nx;
            r_if_rdata  <= w_if_rdata_nx;
            r_if_valid  <= w_if_valid_nx;
            r_d_rdata   <= w_d_rdata_nx;
            r_d_valid   <= w_d_valid_nx;
            r_err_spur  <= w_err_spur_nx;
            r_starve    <= w_starve_nx;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wstrb = r_mem_wstrb;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = r_d_valid;
    assign o_err_spur  = r_err_spur;
    assign o_stall_if  = i_if_req & ~r_if_valid;
    assign o_stall_mem = (i_d_read | i_d_write) & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, scripted memory, directed tests.
module tb_mem_port_arbiter;

    localparam int SMAX = 3;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_valid, o_d_valid, o_stall_if, o_stall_mem;
    logic        o_mem_req, o_mem_we, o_err_spur;
    logic [3:0]  o_mem_wstrb;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
        .i_d_read(d_read), .i_d_write(d_write), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_wstrb(d_wstrb), .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid),
        .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_err_spur(o_err_spur)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h00500093;
            32'h100: return 32'h12345678;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // ---------------- reference model (transaction view) ----------------
    bit          m_busy, m_granted, m_owner_d;
    bit          m_we, m_if_valid, m_d_valid, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_wstrb;
    int          m_starve;
    bit          ifv_prev, dv_prev, d_want, i_want;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_granted = 0; m_owner_d = 0; m_we = 0;
            m_if_valid = 0; m_d_valid = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_if_rdata = '0; m_d_rdata = '0; m_starve = 0;
        end else begin
            ifv_prev = m_if_valid;
            dv_prev  = m_d_valid;
            m_if_valid = 0;
            m_d_valid  = 0;
            if (mem_rvalid && !(m_busy && m_granted)) m_err = 1;
            if (!m_busy) begin
                d_want = (d_read || d_write) && !dv_prev;
                i_want = if_req && !ifv_prev;
                if (d_want && !(i_want && m_starve == SMAX)) begin
                    m_busy = 1; m_owner_d = 1; m_we = d_write; m_addr = d_addr;
                    m_wdata = d_write ? d_wdata : 32'h0;
                    m_wstrb = d_write ? d_wstrb : 4'h0;
                    m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                end else if (i_want) begin
                    m_busy = 1; m_owner_d = 0; m_we = 0; m_addr = if_addr;
                    m_wdata = '0; m_wstrb = '0; m_starve = 0;
                end else if (!if_req) begin
                    m_starve = 0;
                end
            end else if (!m_granted) begin
                if (mem_gnt) m_granted = 1;
            end else if (mem_rvalid) begin
                m_busy = 0; m_granted = 0;
                if (m_owner_d) begin
                    m_d_valid = 1;
                    if (!m_we) m_d_rdata = mem_rdata;
                end else begin
                    m_if_valid = 1;
                    m_if_rdata = mem_rdata;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int req_hi_cnt = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   64'(o_mem_req),   64'(m_busy && !m_granted));
            chk("mem_we",    64'(o_mem_we),    64'(m_we));
            chk("mem_addr",  64'(o_mem_addr),  64'(m_addr));
            chk("mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
            chk("mem_wstrb", 64'(o_mem_wstrb), 64'(m_wstrb));
            chk("if_valid",  64'(o_if_valid),  64'(m_if_valid));
            chk("d_valid",   64'(o_d_valid),   64'(m_d_valid));
            chk("if_rdata",  64'(o_if_rdata),  64'(m_if_rdata));
            chk("d_rdata",   64'(o_d_rdata),   64'(m_d_rdata));
            chk("err_spur",  64'(o_err_spur),  64'(m_err));
            chk("stall_if",  64'(o_stall_if),  64'(if_req && !m_if_valid));
            chk("stall_mem", 64'(o_stall_mem), 64'((d_read || d_write) && !m_d_valid));
        end
        if (o_mem_req === 1'b1) req_hi_cnt++;
    end

    // ---------------- requester agents ----------------
    logic [31:0] if_q[$];
    dreq_t       d_q[$];
    int          if_done_q[$];
    int          d_done_q[$];
    int          if_rise_cyc = 0;
    int          if_valid_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (o_if_valid === 1'b1) begin
            if_done_q.push_back(cyc);
            if_valid_cnt++;
            if (if_q.size() > 0) void'(if_q.pop_front());
        end
        if (!if_req && if_q.size() > 0) if_rise_cyc = cyc;
        if_req  = (if_q.size() > 0);
        if_addr = (if_q.size() > 0) ? if_q[0] : 32'h0;
    end

    always @(posedge clk) begin
        #1;
        if (o_d_valid === 1'b1) begin
            d_done_q.push_back(cyc);
            if (d_q.size() > 0) void'(d_q.pop_front());
        end
        if (d_q.size() > 0) begin
            d_read  = !d_q[0].wr;
            d_write = d_q[0].wr;
            d_addr  = d_q[0].addr;
            d_wdata = d_q[0].wdata;
            d_wstrb = d_q[0].wstrb;
        end else begin
            d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        end
    end

    // ---------------- scripted memory ----------------
    int          gnt_delay = 0;
    bit          hold_resp = 0;
    int          inj_req = 0, inj_ack = 0;
    int          wcnt = 0;
    bit          pend = 0;
    logic [31:0] raddr = '0;

    always @(posedge clk) begin
        #1;
        mem_gnt = 0;
        mem_rvalid = 0;
        if (reset) begin
            pend = 0; wcnt = 0;
        end else if (inj_ack != inj_req) begin
            inj_ack = inj_req;
            mem_rvalid = 1;
            mem_rdata = 32'hBAD0BAD0;
        end else if (pend) begin
            pend = 0;
            mem_rvalid = 1;
            mem_rdata = lookup(raddr);
        end else if (o_mem_req === 1'b1) begin
            if (wcnt >= gnt_delay) begin
                mem_gnt = 1; raddr = o_mem_addr; pend = !hold_resp; wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step(1);
            done = (if_q.size() == 0) && (d_q.size() == 0);
        end
        chk({"done_", nm}, 64'(done), 64'd1);
        step(2);
    endtask

    function automatic dreq_t mk(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        dreq_t r;
        r.wr = wr; r.addr = a; r.wdata = wd; r.wstrb = s;
        return r;
    endfunction

    int d_before, vcnt0;
    bit seen;

    initial begin
        step(1);
        chk_en = 1;
        step(2);
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        chk("rst_err",     64'(o_err_spur), 64'd0);
        chk("rst_if_rdata", 64'(o_if_rdata), 64'd0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
        reset = 0;
        step(2);

        // T1: single fetch with immediate gnt/rvalid
        req_hi_cnt = 0;
        if_done_q.delete();
        if_q.push_back(32'h40);
        wait_done("t1", 40);
        chk("t1_latency", 64'((if_done_q.size() > 0) ? if_done_q[0] - if_rise_cyc : -1), 64'd3);
        chk("t1_rdata", 64'(o_if_rdata), 64'h00500093);
        chk("t1_req_cycles", 64'(req_hi_cnt), 64'd1);
        chk("t1_stall_if", 64'(o_stall_if), 64'd0);

        // T2: fetch and load arrive together; data served first
        if_done_q.delete(); d_done_q.delete();
        if_q.push_back(32'h44);
        d_q.push_back(mk(0, 32'h100, 32'h0, 4'h0));
        wait_done("t2", 60);
        chk("t2_order", 64'((d_done_q.size() > 0 && if_done_q.size() > 0) && (d_done_q[0] < if_done_q[0])), 64'd1);
        chk("t2_d_rdata", 64'(o_d_rdata), 64'h12345678);
        chk("t2_if_rdata", 64'(o_if_rdata), 64'hFFFFFFBB);

        // T3: back-to-back stores while a fetch waits
        if_done_q.delete(); d_done_q.delete();
        for (int i = 0; i < 4; i++) d_q.push_back(mk(1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF));
        if_q.push_back(32'h48);
        wait_done("t3", 120);
        d_before = 0;
        if (if_done_q.size() > 0)
            foreach (d_done_q[i]) if (d_done_q[i] < if_done_q[0]) d_before++;
        chk("t3_if_bounded", 64'(d_before >= 1 && d_before <= SMAX), 64'd1);

        // T4: store with delayed grant; fields stable, d_rdata untouched
        gnt_delay = 4;
        d_q.push_back(mk(1, 32'h200, 32'hDEADBEEF, 4'b0011));
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            seen = (o_mem_req === 1'b1);
        end
        chk("t4_req_seen", 64'(seen), 64'd1);
        chk("t4_we", 64'(o_mem_we), 64'd1);
        chk("t4_wdata", 64'(o_mem_wdata), 64'hDEADBEEF);
        chk("t4_wstrb", 64'(o_mem_wstrb), 64'h3);
        wait_done("t4", 40);
        chk("t4_d_rdata_kept", 64'(o_d_rdata), 64'h12345678);
        gnt_delay = 0;

        // T5: spurious rvalid while idle
        inj_req++;
        step(3);
        chk("t5_err", 64'(o_err_spur), 64'd1);
        if_q.push_back(32'h4C);
        wait_done("t5", 40);
        chk("t5_if_rdata", 64'(o_if_rdata), 64'hFFFFFFB3);

        // T6: reset while waiting for response, then a late rvalid
        hold_resp = 1;
        if_q.push_back(32'h60);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            seen = (o_mem_req === 1'b1);
        end
        step(1);
        chk("t6_in_resp", 64'(o_mem_req), 64'd0);
        vcnt0 = if_valid_cnt;
        reset = 1;
        if_q.delete();
        step(1);
        reset = 0;
        hold_resp = 0;
        chk("t6_err_cleared", 64'(o_err_spur), 64'd0);
        chk("t6_if_rdata_rst", 64'(o_if_rdata), 64'd0);
        step(1);
        inj_req++;
        step(3);
        chk("t6_err_late", 64'(o_err_spur), 64'd1);
        chk("t6_no_valid", 64'(if_valid_cnt - vcnt0), 64'd0);
        if_q.push_back(32'h50);
        wait_done("t6", 40);
        chk("t6_if_rdata", 64'(o_if_rdata), 64'hFFFFFFAF);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
